// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the register-array FIFO family.
package fifo_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'(1) << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_fifo_if.sv
// Producer/consumer side bundle of reg_fifo: requests, read data, flags and error pulses.
interface reg_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/count controller: decides acceptance from the registered flags and
// produces storage write/read strobes, occupancy flags and error pulses.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AW       = clog2(DEPTH),
    parameter int CW       = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic          rd_req,
    output logic          wr_fire,
    output logic [AW-1:0] wr_addr,
    output logic          rd_fire,
    output logic [AW-1:0] rd_addr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THRESH  = CW'(AF_LEVEL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Flags depend only on the registered count, so requests never reach outputs combinationally.
    assign full        = (count == FULL_LEVEL);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_THRESH);

    assign wr_fire = wr_req && !full;
    assign rd_fire = rd_req && !empty;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= wr_req && full;
            underflow <= rd_req && empty;
        end
    end

endmodule

// File: rtl/reg_fifo.sv
// Synchronous FIFO: register-array storage and registered read port around fifo_ctrl.
module reg_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic       clk,
    input  logic       reset,
    reg_fifo_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic             wr_fire;
    logic             rd_fire;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AW       (AW),
        .CW       (CW)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (bus.wr_en),
        .rd_req      (bus.rd_en),
        .wr_fire     (wr_fire),
        .wr_addr     (wr_addr),
        .rd_fire     (rd_fire),
        .rd_addr     (rd_addr),
        .count       (bus.count),
        .full        (bus.full),
        .empty       (bus.empty),
        .almost_full (bus.almost_full),
        .overflow    (bus.overflow),
        .underflow   (bus.underflow)
    );

    // Storage is deliberately left out of reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        rd_q <= '0;
        else if (rd_fire) rd_q <= mem[rd_addr];
    end

    assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_reg_fifo.sv
// Randomised bench for reg_fifo (DEPTH=8 and DEPTH=4 instances) against a queue-based model.
module tb_reg_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_fifo_if #(.WIDTH(4), .DEPTH(8)) b8 ();
    reg_fifo_if #(.WIDTH(4), .DEPTH(4)) b4 ();

    reg_fifo #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(7)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    reg_fifo #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] q8[$];
    logic [3:0] q4[$];
    logic [3:0] rd8, rd4;
    logic ov8, un8, ov4, un4;

    function automatic logic [12:0] obs8();
        return {b8.rd_data, b8.count, b8.full, b8.empty, b8.almost_full, b8.overflow, b8.underflow};
    endfunction

    function automatic logic [12:0] exp8();
        int n = q8.size();
        return {rd8, 4'(n), n == 8, n == 0, n >= 7, ov8, un8};
    endfunction

    function automatic logic [11:0] obs4();
        return {b4.rd_data, b4.count, b4.full, b4.empty, b4.almost_full, b4.overflow, b4.underflow};
    endfunction

    function automatic logic [11:0] exp4();
        int n = q4.size();
        return {rd4, 3'(n), n == 4, n == 0, n >= 3, ov4, un4};
    endfunction

    task automatic model_reset();
        q8.delete(); q4.delete();
        rd8 = '0; rd4 = '0;
        ov8 = 1'b0; un8 = 1'b0; ov4 = 1'b0; un4 = 1'b0;
    endtask

    // One clock: apply requests to both FIFOs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input logic we8, input logic [3:0] wd8, input logic re8,
                       input logic we4, input logic [3:0] wd4, input logic re4);
        bit f, e;
        b8.wr_en = we8; b8.wr_data = wd8; b8.rd_en = re8;
        b4.wr_en = we4; b4.wr_data = wd4; b4.rd_en = re4;
        @(posedge clk);
        f = (q8.size() == 8); e = (q8.size() == 0);
        ov8 = we8 && f; un8 = re8 && e;
        if (re8 && !e) rd8 = q8.pop_front();
        if (we8 && !f) q8.push_back(wd8);
        f = (q4.size() == 4); e = (q4.size() == 0);
        ov4 = we4 && f; un4 = re4 && e;
        if (re4 && !e) rd4 = q4.pop_front();
        if (we4 && !f) q4.push_back(wd4);
        #1;
        b8.wr_en = 1'b0; b8.rd_en = 1'b0;
        b4.wr_en = 1'b0; b4.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        b8.wr_en = 1'b0; b8.wr_data = '0; b8.rd_en = 1'b0;
        b4.wr_en = 1'b0; b4.wr_data = '0; b4.rd_en = 1'b0;
        model_reset();
        #7;
        vectors++;
        if (obs8() !== exp8() || b8.empty !== 1'b1 || b8.rd_data !== 4'h0) begin
            miscompares++;
            $display("FAIL reset8 got %h want %h", obs8(), exp8());
        end
        vectors++;
        if (obs4() !== exp4()) begin
            miscompares++;
            $display("FAIL reset4 got %h want %h", obs4(), exp4());
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_order();
        for (int i = 1; i <= 3; i++) cyc(1, 4'(i), 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            vectors++;
            if (obs8() !== exp8() || b8.rd_data !== 4'(i)) begin
                miscompares++;
                $display("FAIL order[%0d] got %h want %h", i, obs8(), exp8());
            end
        end
        vectors++;
        if (b8.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL order_empty got %b want 1", b8.empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 4'(i), 0, 0, 0, 0);
            vectors++;
            if (obs8() !== exp8() || b8.almost_full !== (i >= 6) || b8.full !== (i == 7)) begin
                miscompares++;
                $display("FAIL fill[%0d] got %h want %h", i, obs8(), exp8());
            end
        end
        cyc(1, 4'h9, 0, 0, 0, 0);
        vectors++;
        if (obs8() !== exp8() || b8.overflow !== 1'b1 || b8.count !== 4'd8) begin
            miscompares++;
            $display("FAIL overflow got %h want %h", obs8(), exp8());
        end
        cyc(0, 0, 0, 0, 0, 0);
        vectors++;
        if (b8.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear got %b want 0", b8.overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            vectors++;
            if (obs8() !== exp8() || b8.rd_data !== 4'(i)) begin
                miscompares++;
                $display("FAIL drain[%0d] got %h want %h", i, obs8(), exp8());
            end
        end
        cyc(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs8() !== exp8() || b8.underflow !== 1'b1 || b8.rd_data !== 4'h7 || b8.count !== 4'd0) begin
            miscompares++;
            $display("FAIL underflow got %h want %h", obs8(), exp8());
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cyc(1, 4'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'($urandom), 1, 0, 0, 0);
            vectors++;
            if (obs8() !== exp8() || b8.count !== 4'd4) begin
                miscompares++;
                $display("FAIL both_mid[%0d] got %h want %h", i, obs8(), exp8());
            end
        end
        while (q8.size() < 8) cyc(1, 4'($urandom), 0, 0, 0, 0);
        cyc(1, 4'($urandom), 1, 0, 0, 0);
        vectors++;
        if (obs8() !== exp8() || b8.overflow !== 1'b1 || b8.count !== 4'd7) begin
            miscompares++;
            $display("FAIL both_full got %h want %h", obs8(), exp8());
        end
        while (q8.size() > 0) cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 4'($urandom), 1, 0, 0, 0);
        vectors++;
        if (obs8() !== exp8() || b8.underflow !== 1'b1 || b8.count !== 4'd1) begin
            miscompares++;
            $display("FAIL both_empty got %h want %h", obs8(), exp8());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i <= 20; i++) begin
            cyc(0, 0, 0, i < 20, 4'($urandom), i > 0);
            vectors++;
            if (obs4() !== exp4()) begin
                miscompares++;
                $display("FAIL wrap[%0d] got %h want %h", i, obs4(), exp4());
            end
        end
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0, 1'($urandom), 4'($urandom), 1'($urandom));
            vectors++;
            if (obs4() !== exp4()) begin
                miscompares++;
                $display("FAIL rand4[%0d] got %h want %h", i, obs4(), exp4());
            end
        end
    endtask

    task automatic test_reset_mid();
        while (q8.size() > 0) cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 4'(i + 3), 0, 0, 0, 0);
        vectors++;
        if (b8.count !== 4'd5) begin
            miscompares++;
            $display("FAIL pre_reset_count got %0d want 5", b8.count);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (obs8() !== exp8()) begin
            miscompares++;
            $display("FAIL async_reset got %h want %h", obs8(), exp8());
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 4'hA, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs8() !== exp8() || b8.rd_data !== 4'hA) begin
            miscompares++;
            $display("FAIL post_reset_data got %h want %h", obs8(), exp8());
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
